// File: rtl/pad_scan_controller.sv
// pad_scan_controller: serial gamepad scanner producing latch/clock waveforms and parallel button words
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   scan_start            single-cycle scan request (ignored while busy)
//   pad_data[1:0]         serial button data, [0]=P1, [1]=P2, 1 = pressed
//   pad_latch, pad_clk    strobes driven to the pads
//   busy                  scan in progress, through the publishing cycle
//   p1/p2_buttons         last completed button words, bit k = k-th serial bit
//   p1/p2_pressed         newly pressed mask from the last completion
//   buttons_valid         one-cycle pulse when the words above update
module pad_scan_controller #(
    parameter int CLK_FREQ     = 24000000,
    parameter int PAD_CLK_FREQ = 1000000,
    parameter int BUTTON_COUNT = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    scan_start,
    input  logic [1:0]              pad_data,
    output logic                    pad_latch,
    output logic                    pad_clk,
    output logic                    busy,
    output logic [BUTTON_COUNT-1:0] p1_buttons,
    output logic [BUTTON_COUNT-1:0] p2_buttons,
    output logic [BUTTON_COUNT-1:0] p1_pressed,
    output logic [BUTTON_COUNT-1:0] p2_pressed,
    output logic                    buttons_valid
);
    localparam int HALF = CLK_FREQ / (2 * PAD_CLK_FREQ);
    localparam int PW   = $clog2(2 * HALF + 2);
    localparam int BW   = $clog2(BUTTON_COUNT + 1);

    if (HALF < 1) begin : g_half_check
        $error("pad_scan_controller: HALF must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, LATCH, CLK_HI, CLK_LO, DONE} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bcnt_q, bcnt_d, k;
    logic [BUTTON_COUNT-1:0] sr1_q, sr1_d, sr2_q, sr2_d;
    logic                    pad_latch_q, pad_clk_q, busy_q, valid_q;
    logic [BUTTON_COUNT-1:0] p1b_q, p2b_q, p1p_q, p2p_q;

    assign k = bcnt_q + BW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + PW'(1);
        bcnt_d  = bcnt_q;
        sr1_d   = sr1_q;
        sr2_d   = sr2_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (scan_start) begin
                    state_d = LATCH;
                    sr1_d   = '0;
                    sr2_d   = '0;
                    bcnt_d  = '0;
                end
            end
            LATCH: if (cnt_q == PW'(2 * HALF - 1)) begin
                cnt_d    = '0;
                sr1_d[0] = pad_data[0];
                sr2_d[0] = pad_data[1];
                state_d  = (BUTTON_COUNT > 1) ? CLK_HI : DONE;
            end
            CLK_HI: if (cnt_q == PW'(HALF - 1)) begin
                cnt_d   = '0;
                state_d = CLK_LO;
            end
            CLK_LO: if (cnt_q == PW'(HALF - 1)) begin
                cnt_d    = '0;
                sr1_d[k] = pad_data[0];
                sr2_d[k] = pad_data[1];
                bcnt_d   = k;
                state_d  = (k == BW'(BUTTON_COUNT - 1)) ? DONE : CLK_HI;
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each strobe lines up with the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bcnt_q      <= '0;
            sr1_q       <= '0;
            sr2_q       <= '0;
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            p1b_q       <= '0;
            p2b_q       <= '0;
            p1p_q       <= '0;
            p2p_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bcnt_q      <= bcnt_d;
            sr1_q       <= sr1_d;
            sr2_q       <= sr2_d;
            pad_latch_q <= state_d == LATCH;
            pad_clk_q   <= state_d == CLK_HI;
            busy_q      <= state_d != IDLE;
            valid_q     <= state_d == DONE;
            if (state_d == DONE) begin
                p1b_q <= sr1_d;
                p2b_q <= sr2_d;
                p1p_q <= sr1_d & ~p1b_q;
                p2p_q <= sr2_d & ~p2b_q;
            end
        end
    end

    assign pad_latch     = pad_latch_q;
    assign pad_clk       = pad_clk_q;
    assign busy          = busy_q;
    assign buttons_valid = valid_q;
    assign p1_buttons    = p1b_q;
    assign p2_buttons    = p2b_q;
    assign p1_pressed    = p1p_q;
    assign p2_pressed    = p2p_q;
endmodule

// File: tb/tb_pad_scan_controller.sv
// tb_pad_scan_controller: table-driven and scoreboard checks of pad_scan_controller with HALF=2, 12 buttons
module tb_pad_scan_controller;
    typedef struct {
        logic [11:0] p1;
        logic [11:0] p2;
        logic [11:0] pr1;
        logic [11:0] pr2;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, scan_start;
    logic [1:0]  pad_data;
    logic        pad_latch, pad_clk, busy, buttons_valid;
    logic [11:0] p1_buttons, p2_buttons, p1_pressed, p2_pressed;

    logic [11:0] p1_pat, p2_pat, prev1, prev2;
    logic [3:0]  idx = 4'd0;
    int          cyc = 0;
    int          npass = 0, ntot = 0;
    int          vcount = 0, lat_cnt = 0, clk_hi = 0, clk_rise = 0, overlap = 0;
    logic        clk_prev = 1'b0;
    vec_t        sb[$];
    vec_t        got;
    vec_t        vecs[4];

    pad_scan_controller #(.CLK_FREQ(4), .PAD_CLK_FREQ(1), .BUTTON_COUNT(12)) dut (
        .clk(clk), .reset(reset), .scan_start(scan_start), .pad_data(pad_data),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .busy(busy),
        .p1_buttons(p1_buttons), .p2_buttons(p2_buttons),
        .p1_pressed(p1_pressed), .p2_pressed(p2_pressed),
        .buttons_valid(buttons_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mock pad: latch reloads to bit 0, each pad_clk rising edge presents the next bit.
    always @(posedge pad_clk or posedge pad_latch)
        if (pad_latch) idx <= 4'd0;
        else idx <= idx + 4'd1;
    assign pad_data = (idx < 4'd12) ? {p2_pat[idx], p1_pat[idx]} : 2'b00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (pad_latch) lat_cnt++;
        if (pad_clk) clk_hi++;
        if (pad_clk && !clk_prev) clk_rise++;
        if (pad_latch && pad_clk) overlap++;
        clk_prev = pad_clk;
        if (buttons_valid) begin
            vcount++;
            if (sb.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                got = sb.pop_front();
                chk("p1_buttons", p1_buttons, got.p1);
                chk("p2_buttons", p2_buttons, got.p2);
                chk("p1_pressed", p1_pressed, got.pr1);
                chk("p2_pressed", p2_pressed, got.pr2);
            end
        end
    end

    task automatic step_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_latch"}, pad_latch, 0);
        chk({nm, "_clk"}, pad_clk, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_valid"}, buttons_valid, 0);
        chk({nm, "_p1b"}, p1_buttons, 0);
        chk({nm, "_p2b"}, p2_buttons, 0);
        chk({nm, "_p1p"}, p1_pressed, 0);
        chk({nm, "_p2p"}, p2_pressed, 0);
    endtask

    task automatic push_exp(input logic [11:0] a, b, pa, pb);
        vec_t e;
        e.p1 = a; e.p2 = b; e.pr1 = pa; e.pr2 = pb;
        sb.push_back(e);
        prev1 = a;
        prev2 = b;
    endtask

    task automatic do_scan(input logic [11:0] a, b, pa, pb);
        int t0, v0;
        @(negedge clk);
        p1_pat = a; p2_pat = b; scan_start = 1'b1;
        t0 = cyc; v0 = vcount;
        push_exp(a, b, pa, pb);
        lat_cnt = 0; clk_hi = 0; clk_rise = 0; overlap = 0;
        step_to(t0 + 1);
        scan_start = 1'b0;
        chk("busy_start", busy, 1);
        chk("latch_start", pad_latch, 1);
        step_to(t0 + 48);
        chk("valid_early", buttons_valid, 0);
        step_to(t0 + 49);
        chk("valid_t49", buttons_valid, 1);
        chk("busy_t49", busy, 1);
        step_to(t0 + 50);
        chk("busy_t50", busy, 0);
        chk("valid_t50", buttons_valid, 0);
        chk("valid_count", vcount - v0, 1);
        chk("latch_cycles", lat_cnt, 4);
        chk("clk_pulses", clk_rise, 11);
        chk("clk_hi_cycles", clk_hi, 22);
        chk("latch_clk_overlap", overlap, 0);
    endtask

    initial begin
        int t0, v0;
        vecs[0] = '{12'hA5C, 12'h3F0, 12'hA5C, 12'h3F0};
        vecs[1] = '{12'hA5D, 12'h3F0, 12'h001, 12'h000};
        vecs[2] = '{12'h000, 12'hFFF, 12'h000, 12'hC0F};
        vecs[3] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000};
        reset = 1'b1; scan_start = 1'b0; p1_pat = '0; p2_pat = '0; prev1 = '0; prev2 = '0;
        repeat (2) @(negedge clk);
        chk_zero("rst");
        reset = 1'b0;

        // Reset during LATCH abandons the scan and the block stays idle afterwards.
        @(negedge clk);
        scan_start = 1'b1; t0 = cyc;
        step_to(t0 + 1);
        scan_start = 1'b0;
        step_to(t0 + 2);
        chk("latch_before_rst", pad_latch, 1);
        #2 reset = 1'b1;
        #1 chk_zero("rst_latch");
        @(negedge clk);
        reset = 1'b0;
        v0 = vcount;
        repeat (100) @(negedge clk);
        chk("idle_no_valid", vcount - v0, 0);
        chk("idle_busy", busy, 0);
        chk("idle_latch", pad_latch, 0);

        for (int i = 0; i < 4; i++) do_scan(vecs[i].p1, vecs[i].p2, vecs[i].pr1, vecs[i].pr2);

        // Requests at T0+10 and in the DONE cycle are dropped; the one at T0+50 starts the next scan.
        @(negedge clk);
        p1_pat = 12'h0F0; p2_pat = 12'h00F; scan_start = 1'b1; t0 = cyc; v0 = vcount;
        push_exp(12'h0F0, 12'h00F, 12'h0F0 & ~prev1, 12'h00F & ~prev2);
        step_to(t0 + 1);
        scan_start = 1'b0;
        step_to(t0 + 10);
        scan_start = 1'b1;
        step_to(t0 + 11);
        scan_start = 1'b0;
        step_to(t0 + 49);
        chk("ign_valid_t49", buttons_valid, 1);
        scan_start = 1'b1;
        step_to(t0 + 50);
        chk("ign_busy_t50", busy, 0);
        chk("ign_one_valid", vcount - v0, 1);
        p1_pat = 12'hF00; p2_pat = 12'h00F;
        push_exp(12'hF00, 12'h00F, 12'hF00 & ~prev1, 12'h00F & ~prev2);
        step_to(t0 + 51);
        scan_start = 1'b0;
        chk("b2b_latch_t51", pad_latch, 1);
        chk("b2b_busy_t51", busy, 1);
        step_to(t0 + 98);
        chk("b2b_valid_t98", buttons_valid, 0);
        step_to(t0 + 99);
        chk("b2b_valid_t99", buttons_valid, 1);
        step_to(t0 + 100);
        chk("b2b_valid_count", vcount - v0, 2);
        chk("b2b_busy_t100", busy, 0);

        // Reset in the CLK_LO phase of bit 6 clears everything and publishes nothing.
        @(negedge clk);
        p1_pat = 12'hFFF; p2_pat = 12'hFFF; scan_start = 1'b1; t0 = cyc;
        step_to(t0 + 1);
        scan_start = 1'b0;
        step_to(t0 + 26);
        chk("bit6_clk_hi", pad_clk, 1);
        step_to(t0 + 27);
        chk("bit6_clk_lo", pad_clk, 0);
        chk("bit6_busy", busy, 1);
        #2 reset = 1'b1;
        #1 chk_zero("rst_clklo");
        @(negedge clk);
        reset = 1'b0; prev1 = '0; prev2 = '0; v0 = vcount;
        repeat (60) @(negedge clk);
        chk("no_partial", vcount - v0, 0);
        do_scan(12'h123, 12'h456, 12'h123, 12'h456);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
